// File: rtl/sqr_wave_pkg.sv
// Shared types and limits for the square-wave segment sequencer.
package sqr_wave_pkg;

   typedef struct packed {
      logic [3:0] m;
      logic [3:0] n;
      logic [3:0] rep;
   } seg_t;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      STOPPING
   } seq_state_t;

   localparam int UNIT_MAX = 15;

endpackage

// File: rtl/sqr_period_gen.sv
// Period generator: down-counter over one (m+n)*TICK_DIV period with a registered
// high/low compare; reloads itself while hold is asserted.
module sqr_period_gen
   import sqr_wave_pkg::*;
#(
   parameter int TICK_DIV = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       hold,
   input  logic [3:0] m,
   input  logic [3:0] n,
   output logic       out,
   output logic       period_end
);

   localparam int CW = $clog2(2 * UNIT_MAX * TICK_DIV);
   localparam logic [CW-1:0] ONE = CW'(1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] per_q, per_d;
   logic [CW-1:0] lo_q, lo_d;
   logic          act_q, act_d;
   logic          out_d;

   assign period_end = act_q && (cnt_q == '0);

   // Counter value c maps to position per-1-c in the period, so out is high
   // exactly while c is at or above the low-phase length.
   always_comb begin
      per_d = per_q;
      lo_d  = lo_q;
      act_d = 1'b0;
      cnt_d = '0;
      if (load) begin
         per_d = (CW'(m) + CW'(n)) * CW'(TICK_DIV);
         lo_d  = CW'(n) * CW'(TICK_DIV);
         act_d = 1'b1;
         cnt_d = per_d - ONE;
      end else if (act_q && hold) begin
         act_d = 1'b1;
         cnt_d = period_end ? (per_q - ONE) : (cnt_q - ONE);
      end
      out_d = act_d && (cnt_d >= lo_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         per_q <= '0;
         lo_q  <= '0;
         act_q <= 1'b0;
         out   <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         per_q <= per_d;
         lo_q  <= lo_d;
         act_q <= act_d;
         out   <= out_d;
      end
   end

endmodule

// File: rtl/sqr_wave_sequencer.sv
// Segment scheduler: plays table entries 0..last_idx through the period generator.
//   state    | meaning
//   IDLE     | output low, waiting for start
//   LOAD     | one cycle: fetch entry cur_idx, skip it if m+n==0
//   RUN      | periods of the current entry playing, rep counter running
//   STOPPING | stop seen, finishing the current period
module sqr_wave_sequencer
   import sqr_wave_pkg::*;
#(
   parameter  int DEPTH    = 8,
   parameter  int TICK_DIV = 10,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [3:0]    wr_m,
   input  logic [3:0]    wr_n,
   input  logic [3:0]    wr_rep,
   input  logic [AW-1:0] last_idx,
   input  logic          loop_en,
   input  logic          start,
   input  logic          stop,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] cur_idx,
   output logic          out
);

   seg_t          tbl [DEPTH];
   seg_t          cur_seg;
   seq_state_t    state_q, state_d, adv_state;
   logic [AW-1:0] idx_d, adv_idx, last_q, last_d;
   logic [3:0]    rep_q, rep_d;
   logic          loop_q, loop_d;
   logic          gen_load, gen_hold, period_end;

   always_ff @(posedge clk) begin
      if (wr_en) tbl[wr_addr] <= {wr_m, wr_n, wr_rep};
   end

   assign cur_seg = tbl[cur_idx];

   always_comb begin
      adv_state = IDLE;
      adv_idx   = cur_idx;
      if (cur_idx < last_q) begin
         adv_state = LOAD;
         adv_idx   = cur_idx + AW'(1);
      end else if (loop_q) begin
         adv_state = LOAD;
         adv_idx   = '0;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = cur_idx;
      rep_d    = rep_q;
      last_d   = last_q;
      loop_d   = loop_q;
      gen_load = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d = LOAD;
            idx_d   = '0;
            last_d  = last_idx;
            loop_d  = loop_en;
         end
         LOAD: begin
            if (stop) begin
               state_d = IDLE;
            end else if (cur_seg.m == 4'd0 && cur_seg.n == 4'd0) begin
               state_d = adv_state;
               idx_d   = adv_idx;
            end else begin
               state_d  = RUN;
               gen_load = 1'b1;
               rep_d    = (cur_seg.rep == 4'd0) ? 4'd1 : cur_seg.rep;
            end
         end
         RUN: begin
            if (period_end) begin
               if (stop) begin
                  state_d = IDLE;
               end else if (rep_q == 4'd1) begin
                  state_d = adv_state;
                  idx_d   = adv_idx;
               end else begin
                  rep_d = rep_q - 4'd1;
               end
            end else if (stop) begin
               state_d = STOPPING;
            end
         end
         STOPPING: if (period_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign gen_hold = (state_d == RUN) || (state_d == STOPPING);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cur_idx <= '0;
         rep_q   <= '0;
         last_q  <= '0;
         loop_q  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_idx <= idx_d;
         rep_q   <= rep_d;
         last_q  <= last_d;
         loop_q  <= loop_d;
         busy    <= (state_d != IDLE);
         done    <= (state_q != IDLE) && (state_d == IDLE);
      end
   end

   sqr_period_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_period_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (gen_load),
      .hold       (gen_hold),
      .m          (cur_seg.m),
      .n          (cur_seg.n),
      .out        (out),
      .period_end (period_end)
   );

endmodule

// File: tb/tb_sqr_wave_sequencer.sv
// Scoreboard bench: expected out run-lengths and done latencies are queued by the
// driver; a negedge monitor compresses out into runs while busy and pops/compares.
module tb_sqr_wave_sequencer;

   localparam int DEPTH    = 8;
   localparam int TICK_DIV = 10;
   localparam int AW       = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [3:0]    wr_m = '0, wr_n = '0, wr_rep = '0;
   logic [AW-1:0] last_idx = '0;
   logic          loop_en = 1'b0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          busy, done, out;
   logic [AW-1:0] cur_idx;

   sqr_wave_sequencer #(
      .DEPTH    (DEPTH),
      .TICK_DIV (TICK_DIV)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_m     (wr_m),
      .wr_n     (wr_n),
      .wr_rep   (wr_rep),
      .last_idx (last_idx),
      .loop_en  (loop_en),
      .start    (start),
      .stop     (stop),
      .busy     (busy),
      .done     (done),
      .cur_idx  (cur_idx),
      .out      (out)
   );

   always #5 clk = ~clk;

   // kind 0: a run of constant out while busy (lvl, len cycles)
   // kind 1: done pulse, len = cycles from start request to done
   typedef struct {
      int kind;
      int lvl;
      int len;
   } tok_t;

   tok_t  sbq[$];
   int    tests = 0, fails = 0;
   int    cyc = 0, start_cyc = 0;
   int    run_lvl = 0, run_len = 0;
   string tname = "reset";

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s/%s: got %0d expected %0d", tname, name, act, exp);
      end
   endtask

   task automatic observe(input int kind, input int lvl, input int len);
      tok_t e;
      if (sbq.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL %s/unexpected_%s: got lvl=%0d len=%0d expected no event",
                  tname, (kind == 1) ? "done" : "run", lvl, len);
      end else begin
         e = sbq.pop_front();
         check("event_kind", kind, e.kind);
         if (kind == e.kind) begin
            if (kind == 0) check("run_level", lvl, e.lvl);
            check((kind == 1) ? "done_latency" : "run_length", len, e.len);
         end
      end
   endtask

   always @(negedge clk) begin
      if (busy === 1'b1) begin
         if (run_len > 0 && int'(out) == run_lvl) begin
            run_len++;
         end else begin
            if (run_len > 0) observe(0, run_lvl, run_len);
            run_lvl = int'(out);
            run_len = 1;
         end
      end else if (run_len > 0) begin
         observe(0, run_lvl, run_len);
         run_len = 0;
      end
      if (done === 1'b1) observe(1, 0, cyc - start_cyc);
   end

   task automatic ticks(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic write_entry(input int a, input int m, input int n, input int r);
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_m    = 4'(m);
      wr_n    = 4'(n);
      wr_rep  = 4'(r);
      ticks(1);
      wr_en   = 1'b0;
   endtask

   task automatic exp_run(input int lvl, input int len);
      tok_t t;
      t.kind = 0; t.lvl = lvl; t.len = len;
      sbq.push_back(t);
   endtask

   task automatic exp_done(input int lat);
      tok_t t;
      t.kind = 1; t.lvl = 0; t.len = lat;
      sbq.push_back(t);
   endtask

   // Called at a negedge; returns at the negedge inside the LOAD cycle.
   task automatic issue_start(input logic with_stop);
      start     = 1'b1;
      stop      = with_stop;
      start_cyc = cyc;
      ticks(1);
      start     = 1'b0;
      stop      = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      ticks(1);
      stop = 1'b0;
   endtask

   task automatic finish_test(input int limit);
      int k = 0;
      while (busy === 1'b1 && k < limit) begin
         ticks(1);
         k++;
      end
      if (busy === 1'b1) begin
         tests++;
         fails++;
         $display("FAIL %s/timeout: busy still 1 after %0d cycles, expected 0", tname, limit);
      end
      ticks(2);
      check("leftover_events", sbq.size(), 0);
      sbq.delete();
   endtask

   initial begin
      ticks(3);
      check("out_rst", int'(out), 0);
      check("busy_rst", int'(busy), 0);
      check("done_rst", int'(done), 0);
      check("idx_rst", int'(cur_idx), 0);
      rst_n = 1'b1;
      ticks(2);

      tname = "single_entry";
      write_entry(0, 2, 3, 1);
      last_idx = 3'd0; loop_en = 1'b0;
      exp_run(0, 1); exp_run(1, 20); exp_run(0, 30); exp_done(52);
      issue_start(1'b0);
      finish_test(200);

      tname = "two_entries";
      write_entry(0, 1, 1, 2);
      write_entry(1, 3, 0, 1);
      last_idx = 3'd1;
      exp_run(0, 1); exp_run(1, 10); exp_run(0, 10); exp_run(1, 10);
      exp_run(0, 11); exp_run(1, 30); exp_done(73);
      issue_start(1'b0);
      ticks(50);
      check("idx_entry1", int'(cur_idx), 1);
      finish_test(200);

      tname = "loop_stop";
      write_entry(0, 1, 1, 1);
      write_entry(1, 1, 2, 1);
      last_idx = 3'd1; loop_en = 1'b1;
      exp_run(0, 1); exp_run(1, 10); exp_run(0, 11); exp_run(1, 10);
      exp_run(0, 21); exp_run(1, 10); exp_run(0, 10); exp_done(74);
      issue_start(1'b0);
      ticks(57);
      check("idx_replay", int'(cur_idx), 0);
      pulse_stop();
      finish_test(200);

      tname = "skip_empty";
      write_entry(0, 1, 1, 1);
      write_entry(1, 0, 0, 5);
      write_entry(2, 1, 0, 0);
      last_idx = 3'd2; loop_en = 1'b0;
      exp_run(0, 1); exp_run(1, 10); exp_run(0, 12); exp_run(1, 10); exp_done(34);
      issue_start(1'b0);
      finish_test(200);

      tname = "reset_mid_run";
      write_entry(0, 2, 2, 1);
      last_idx = 3'd0;
      exp_run(0, 1); exp_run(1, 10);
      issue_start(1'b0);
      ticks(5);
      start = 1'b1;
      ticks(1);
      start = 1'b0;
      ticks(4);
      #1 rst_n = 1'b0;
      #1;
      check("out_async", int'(out), 0);
      check("busy_async", int'(busy), 0);
      check("done_async", int'(done), 0);
      ticks(2);
      rst_n = 1'b1;
      finish_test(200);

      tname = "rewrite_playing";
      write_entry(0, 1, 1, 2);
      last_idx = 3'd0; loop_en = 1'b1;
      exp_run(0, 1); exp_run(1, 10); exp_run(0, 10); exp_run(1, 10);
      exp_run(0, 11); exp_run(1, 30); exp_run(0, 10); exp_done(83);
      issue_start(1'b0);
      ticks(5);
      write_entry(0, 3, 1, 1);
      ticks(44);
      pulse_stop();
      finish_test(300);

      tname = "stop_at_period_end";
      write_entry(0, 1, 1, 3);
      loop_en = 1'b0;
      exp_run(0, 1); exp_run(1, 10); exp_run(0, 10); exp_done(22);
      issue_start(1'b0);
      ticks(20);
      pulse_stop();
      finish_test(200);

      tname = "start_stop_idle";
      write_entry(0, 1, 0, 1);
      exp_run(0, 1); exp_run(1, 10); exp_done(12);
      issue_start(1'b1);
      finish_test(200);

      tname = "stop_in_load";
      exp_run(0, 1); exp_done(2);
      issue_start(1'b0);
      pulse_stop();
      finish_test(200);
      check("out_after_load_stop", int'(out), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
